// File: rtl/main_system_pll_sup_pkg.sv
// Shared types and constants for the main-system PLL supervisor.
// Optional loss glitch filter: PLL_SUP_LOSS_FILTER_EN.
package main_system_pll_sup_pkg;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAILED    = 3'd4
  } pll_sup_state_t;

  localparam int LOCK_LOSS_CNT_W = 8;

  // Counter width for a terminal count of n, never below one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/main_system_pll_supervisor_if.sv
// Control/status bundle between the PLL supervisor and its environment.
// Optional loss glitch filter: PLL_SUP_LOSS_FILTER_EN.
interface main_system_pll_supervisor_if;
  import main_system_pll_sup_pkg::*;

  logic                       pll_locked;
  logic                       restart;
  logic                       pll_rst;
  logic                       sys_rst;
  logic                       fail;
  logic [2:0]                 state_o;
  logic [LOCK_LOSS_CNT_W-1:0] lock_loss_cnt;

  modport master (
    output pll_locked,
    output restart,
    input  pll_rst,
    input  sys_rst,
    input  fail,
    input  state_o,
    input  lock_loss_cnt
  );

  modport slave (
    input  pll_locked,
    input  restart,
    output pll_rst,
    output sys_rst,
    output fail,
    output state_o,
    output lock_loss_cnt
  );

endinterface

// File: rtl/pll_sup_sync2.sv
// Generic 1-bit two-flop synchronizer with synchronous clear to 0.
// Optional loss glitch filter: PLL_SUP_LOSS_FILTER_EN (not used here).
module pll_sup_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/main_system_pll_supervisor.sv
// PLL reset/lock supervisor: sequences pll_rst, qualifies lock, gates sys_rst.
// Define PLL_SUP_LOSS_FILTER_EN to glitch-filter lock loss while in RUN.
module main_system_pll_supervisor
  import main_system_pll_sup_pkg::*;
#(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES         = 3,
  parameter int LOSS_FILTER_CYCLES  = 4
) (
  input logic                          refclk,
  input logic                          rst,
  main_system_pll_supervisor_if.slave  bus
);

  localparam int RST_W = cnt_w(PLL_RST_CYCLES);
  localparam int TMO_W = cnt_w(LOCK_TIMEOUT_CYCLES);
  localparam int STB_W = cnt_w(LOCK_STABLE_CYCLES);
  localparam int RTY_W = cnt_w(MAX_RETRIES);

  localparam logic [RST_W-1:0] RST_LAST = RST_W'(PLL_RST_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [STB_W-1:0] STB_LAST = STB_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RTY_W-1:0] RTY_LAST = RTY_W'(MAX_RETRIES - 1);

  pll_sup_state_t state, state_n;

  logic [RST_W-1:0] rst_cnt, rst_cnt_n;
  logic [TMO_W-1:0] tmo_cnt, tmo_cnt_n;
  logic [STB_W-1:0] stb_cnt, stb_cnt_n;
  logic [RTY_W-1:0] rty_cnt, rty_cnt_n;

  logic locked_s;
  logic loss;
  logic loss_inc;
  logic tmo_done;

  pll_sup_sync2 u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (bus.pll_locked),
    .q   (locked_s)
  );

`ifdef PLL_SUP_LOSS_FILTER_EN
  localparam int FLT_W = cnt_w(LOSS_FILTER_CYCLES);
  localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(LOSS_FILTER_CYCLES - 1);

  logic [FLT_W-1:0] flt_cnt, flt_cnt_n;

  // Loss is only recognised after a full run of low samples in RUN.
  always_comb begin
    loss      = 1'b0;
    flt_cnt_n = '0;
    if (state == RUN && !locked_s) begin
      if (flt_cnt == FLT_LAST) loss = 1'b1;
      else flt_cnt_n = flt_cnt + 1'b1;
    end
  end

  always_ff @(posedge refclk) begin
    if (rst || bus.restart) flt_cnt <= '0;
    else flt_cnt <= flt_cnt_n;
  end
`else
  logic unused_flt;
  assign unused_flt = ^LOSS_FILTER_CYCLES;
  assign loss = (state == RUN) && !locked_s;
`endif

  assign tmo_done = (tmo_cnt == TMO_LAST);

  always_comb begin
    state_n   = state;
    rst_cnt_n = rst_cnt;
    tmo_cnt_n = tmo_cnt;
    stb_cnt_n = stb_cnt;
    rty_cnt_n = rty_cnt;
    loss_inc  = 1'b0;
    if (bus.restart) begin
      state_n   = PLL_RST;
      rst_cnt_n = '0;
      tmo_cnt_n = '0;
      stb_cnt_n = '0;
      rty_cnt_n = '0;
    end else begin
      unique case (state)
        PLL_RST: begin
          if (rst_cnt == RST_LAST) begin
            state_n   = WAIT_LOCK;
            tmo_cnt_n = '0;
          end else begin
            rst_cnt_n = rst_cnt + 1'b1;
          end
        end
        WAIT_LOCK, STABLE: begin
          if (!tmo_done) tmo_cnt_n = tmo_cnt + 1'b1;
          if (state == WAIT_LOCK && locked_s) begin
            state_n   = STABLE;
            stb_cnt_n = '0;
          end else if (state == STABLE && locked_s &&
                       stb_cnt == STB_LAST) begin
            state_n   = RUN;
            rty_cnt_n = '0;
          end else if (tmo_done) begin
            // Retry budget spent: park; otherwise re-pulse the PLL.
            if (rty_cnt == RTY_LAST) begin
              state_n = FAILED;
            end else begin
              state_n   = PLL_RST;
              rst_cnt_n = '0;
              rty_cnt_n = rty_cnt + 1'b1;
            end
          end else if (state == STABLE) begin
            if (!locked_s) state_n = WAIT_LOCK;
            else stb_cnt_n = stb_cnt + 1'b1;
          end
        end
        RUN: begin
          if (loss) begin
            state_n   = PLL_RST;
            rst_cnt_n = '0;
            loss_inc  = 1'b1;
          end
        end
        FAILED: begin
          state_n = FAILED;
        end
        default: begin
          state_n   = PLL_RST;
          rst_cnt_n = '0;
        end
      endcase
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state             <= PLL_RST;
      rst_cnt           <= '0;
      tmo_cnt           <= '0;
      stb_cnt           <= '0;
      rty_cnt           <= '0;
      bus.pll_rst       <= 1'b1;
      bus.sys_rst       <= 1'b1;
      bus.fail          <= 1'b0;
      bus.lock_loss_cnt <= '0;
    end else begin
      state       <= state_n;
      rst_cnt     <= rst_cnt_n;
      tmo_cnt     <= tmo_cnt_n;
      stb_cnt     <= stb_cnt_n;
      rty_cnt     <= rty_cnt_n;
      bus.pll_rst <= (state_n == PLL_RST);
      bus.sys_rst <= (state_n != RUN);
      bus.fail    <= (state_n == FAILED);
      if (loss_inc && bus.lock_loss_cnt != '1)
        bus.lock_loss_cnt <= bus.lock_loss_cnt + 1'b1;
    end
  end

  assign bus.state_o = state;

endmodule

// File: tb/tb_main_system_pll_supervisor.sv
// Directed bench for main_system_pll_supervisor.
// Build with PLL_SUP_LOSS_FILTER_EN to exercise the filtered-loss variant.
module tb_main_system_pll_supervisor;

  localparam int PRC = 4;
  localparam int LTC = 100;
  localparam int LSC = 8;
  localparam int MR  = 2;
`ifdef PLL_SUP_LOSS_FILTER_EN
  localparam int EXP_LOSS = 0;
`else
  localparam int EXP_LOSS = 3;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;
  int   n;
  int   stb_at;
  int   pr_seen;
  int   exp_cnt;

  main_system_pll_supervisor_if bus ();

  main_system_pll_supervisor #(
    .PLL_RST_CYCLES      (PRC),
    .LOCK_TIMEOUT_CYCLES (LTC),
    .LOCK_STABLE_CYCLES  (LSC),
    .MAX_RETRIES         (MR),
    .LOSS_FILTER_CYCLES  (4)
  ) dut (
    .refclk (clk),
    .rst    (rst),
    .bus    (bus)
  );

  always #10 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pll_rst"}, bus.pll_rst, 1);
    chk({tag, "_sys_rst"}, bus.sys_rst, 1);
    chk({tag, "_fail"}, bus.fail, 0);
    chk({tag, "_state"}, bus.state_o, 0);
    chk({tag, "_loss_cnt"}, bus.lock_loss_cnt, 0);
  endtask

  task automatic pulse_restart;
    bus.restart = 1'b1;
    tick;
    bus.restart = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] s, input string tag);
    n = 0;
    while (bus.state_o !== s && n < 40) begin
      tick;
      n++;
    end
    chk(tag, bus.state_o, s);
  endtask

  task automatic wait_release(input string tag);
    n = 0;
    while (bus.sys_rst !== 1'b0 && n < 60) begin
      tick;
      n++;
    end
    chk(tag, bus.sys_rst, 0);
  endtask

  initial begin
    rst = 1'b1;
    bus.pll_locked = 1'b0;
    bus.restart = 1'b0;
    repeat (3) tick;
    chk_reset_vals("rst0");
    rst = 1'b0;

    // T1: power-up sequence
    n = 0;
    do begin
      tick;
      n++;
    end while (bus.pll_rst && n < 20);
    chk("t1_pll_rst_len", n, PRC);
    chk("t1_wait", bus.state_o, 1);
    repeat (10) tick;
    chk("t1_still_wait", bus.state_o, 1);
    chk("t1_sys_rst_hi", bus.sys_rst, 1);
    bus.pll_locked = 1'b1;
    n = 0;
    stb_at = 0;
    do begin
      tick;
      n++;
      if (stb_at == 0 && bus.state_o == 3'd2) stb_at = n;
    end while (bus.sys_rst && n < 40);
    chk("t1_stable_at", stb_at, 3);
    chk("t1_release", n, LSC + 3);
    chk("t1_run", bus.state_o, 3);
    chk("t1_pll_rst_lo", bus.pll_rst, 0);

    // T4: single-cycle drops in RUN
    for (int k = 1; k <= 3; k++) begin
      bus.pll_locked = 1'b0;
      tick;
      bus.pll_locked = 1'b1;
`ifdef PLL_SUP_LOSS_FILTER_EN
      repeat (10) tick;
      chk("t4_ignored_sys_rst", bus.sys_rst, 0);
      chk("t4_ignored_state", bus.state_o, 3);
      chk("t4_ignored_cnt", bus.lock_loss_cnt, 0);
`else
      n = 1;
      while (!bus.sys_rst && n < 20) begin
        tick;
        n++;
      end
      chk("t4_sys_rst_lat", n, 3);
      chk("t4_pll_rst_rise", bus.pll_rst, 1);
      n = 0;
      while (bus.pll_rst && n < 20) begin
        n++;
        tick;
      end
      chk("t4_pll_rst_len", n, PRC);
      wait_release("t4_relock");
      chk("t4_loss_cnt", bus.lock_loss_cnt, k);
`endif
    end

    // T3: restart from RUN, then glitch in STABLE at count 5
    pulse_restart;
    chk("t3_rs_state", bus.state_o, 0);
    chk("t3_rs_pll_rst", bus.pll_rst, 1);
    chk("t3_rs_sys_rst", bus.sys_rst, 1);
    chk("t3_rs_loss_kept", bus.lock_loss_cnt, EXP_LOSS);
    wait_state(3'd2, "t3_reach_stable");
    repeat (3) tick;
    bus.pll_locked = 1'b0;
    tick;
    bus.pll_locked = 1'b1;
    repeat (2) tick;
    chk("t3_back_to_wait", bus.state_o, 1);
    n = 6;
    pr_seen = 0;
    while (bus.sys_rst && n < 40) begin
      tick;
      n++;
      if (bus.pll_rst) pr_seen = 1;
    end
    chk("t3_release_at", n, 15);
    chk("t3_no_pll_rst", pr_seen, 0);

    // T2: lock never arrives
    bus.pll_locked = 1'b0;
    pulse_restart;
    for (int a = 0; a < 2; a++) begin
      wait_state(3'd1, "t2_enter_wait");
      n = 0;
      while (bus.state_o == 3'd1 && n < 200) begin
        tick;
        n++;
      end
      chk("t2_wait_len", n, LTC);
      chk("t2_after_tmo", bus.state_o, (a == 0) ? 0 : 4);
    end
    chk("t2_fail", bus.fail, 1);
    chk("t2_sys_rst", bus.sys_rst, 1);
    chk("t2_pll_rst", bus.pll_rst, 0);
    bus.pll_locked = 1'b1;
    repeat (5) tick;
    chk("t2_sticky", bus.state_o, 4);
    pulse_restart;
    chk("t2_rs_state", bus.state_o, 0);
    chk("t2_rs_fail", bus.fail, 0);
    chk("t2_rs_pll_rst", bus.pll_rst, 1);
    wait_release("t2_relock");
    chk("t2_run", bus.state_o, 3);

    // T5b: restart coinciding with the final timeout
    bus.pll_locked = 1'b0;
    pulse_restart;
    wait_state(3'd1, "t5_wait1");
    n = 0;
    while (bus.state_o == 3'd1 && n < 200) begin
      tick;
      n++;
    end
    wait_state(3'd1, "t5_wait2");
    repeat (LTC - 1) tick;
    chk("t5_pre_expiry", bus.state_o, 1);
    pulse_restart;
    chk("t5_restart_wins", bus.state_o, 0);
    chk("t5_no_fail", bus.fail, 0);
    chk("t5_pll_rst", bus.pll_rst, 1);
    wait_state(3'd1, "t5_wait3");
    n = 0;
    while (bus.state_o == 3'd1 && n < 200) begin
      tick;
      n++;
    end
    chk("t5_retry_cleared", bus.state_o, 0);
    bus.pll_locked = 1'b1;
    pulse_restart;
    wait_release("t5_relock");

    // T6: saturation of the loss counter
    exp_cnt = EXP_LOSS;
    for (int k = 0; k < 260; k++) begin
      bus.pll_locked = 1'b0;
      repeat (8) tick;
      bus.pll_locked = 1'b1;
      wait_release("t6_relock");
      if (exp_cnt < 255) exp_cnt++;
      chk("t6_loss_cnt", bus.lock_loss_cnt, exp_cnt);
    end
    chk("t6_saturated", bus.lock_loss_cnt, 255);

    // T5a: synchronous reset in the middle of STABLE
    pulse_restart;
    wait_state(3'd2, "t5_reach_stable");
    repeat (3) tick;
    rst = 1'b1;
    tick;
    chk_reset_vals("t5_rst");
    rst = 1'b0;
    tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
